// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types and constants for the intersection controller.
package traffic_pkg;

    // Controller phases.
    typedef enum logic [2:0] {
        ST_ALL_RED = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_WALK    = 3'd3,
        ST_FLASH   = 3'd4
    } tl_state_t;

    // Per-approach lamp encodings, {red, yellow, green}.
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    // Larger of two integers; used to size the phase timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Loadable down-counter that times each controller phase.
// done is high while the count is zero; the count parks at zero.
module phase_timer #(
    parameter int W         = 4,
    parameter int RESET_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load wins, otherwise count down while enabled.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= W'(RESET_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Multi-approach intersection controller: green/yellow/all-red sequencing,
// latched pedestrian walk phase, flashing-yellow maintenance mode and a
// global freeze enable. All outputs decode registered state only.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR        = 2,
    parameter int GREEN_CYCLES   = 8,
    parameter int YELLOW_CYCLES  = 3,
    parameter int ALL_RED_CYCLES = 2,
    parameter int WALK_CYCLES    = 6,
    parameter int FLASH_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 flash_mode,
    input  logic                 ped_req,
    output logic [3*NUM_DIR-1:0] lights,
    output logic                 ped_walk,
    output logic [1:0]           cur_dir,
    output logic                 in_flash
);

    localparam int MAX_DUR = max_int(max_int(max_int(GREEN_CYCLES, YELLOW_CYCLES),
                                             max_int(ALL_RED_CYCLES, WALK_CYCLES)),
                                     FLASH_CYCLES);
    localparam int TIMER_W = $clog2(MAX_DUR) + 1;

    localparam logic [TIMER_W-1:0] GREEN_LD   = TIMER_W'(GREEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LD  = TIMER_W'(YELLOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ALL_RED_LD = TIMER_W'(ALL_RED_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WALK_LD    = TIMER_W'(WALK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] FLASH_LD   = TIMER_W'(FLASH_CYCLES - 1);
    localparam logic [1:0]         LAST_DIR   = 2'(NUM_DIR - 1);

    // Reject illegal configurations at elaboration.
    if (NUM_DIR < 2 || NUM_DIR > 4) begin : g_bad_num_dir
        $error("traffic_light_ctrl: NUM_DIR must be in 2..4");
    end
    if (GREEN_CYCLES < 1 || YELLOW_CYCLES < 1 || ALL_RED_CYCLES < 1 ||
        WALK_CYCLES < 1 || FLASH_CYCLES < 1) begin : g_bad_duration
        $error("traffic_light_ctrl: every duration must be at least 1");
    end

    tl_state_t          state_q, state_d;
    logic [1:0]         cur_dir_q, cur_dir_d;
    logic               ped_pending_q, ped_pending_d;
    logic               walked_q, walked_d;
    logic               toggle_q, toggle_d;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_done;

    phase_timer #(
        .W         (TIMER_W),
        .RESET_VAL (ALL_RED_CYCLES - 1)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (en),
        .done     (timer_done)
    );

    // Next-state logic: a phase ends when its timer is at zero in an enabled cycle.
    always_comb begin
        state_d        = state_q;
        cur_dir_d      = cur_dir_q;
        walked_d       = walked_q;
        toggle_d       = toggle_q;
        timer_load     = 1'b0;
        timer_load_val = '0;
        // Requests are latched outside WALK; the walk itself absorbs them.
        ped_pending_d  = ped_pending_q | (ped_req && (state_q != ST_WALK));

        if (en && timer_done) begin
            timer_load = 1'b1;
            unique case (state_q)
                ST_GREEN: begin
                    state_d        = ST_YELLOW;
                    timer_load_val = YELLOW_LD;
                end
                ST_YELLOW: begin
                    state_d        = ST_ALL_RED;
                    timer_load_val = ALL_RED_LD;
                end
                ST_ALL_RED: begin
                    if (flash_mode) begin
                        state_d        = ST_FLASH;
                        toggle_d       = 1'b0;
                        timer_load_val = FLASH_LD;
                    end else if (ped_pending_q && !walked_q) begin
                        state_d        = ST_WALK;
                        ped_pending_d  = 1'b0;
                        timer_load_val = WALK_LD;
                    end else begin
                        state_d        = ST_GREEN;
                        cur_dir_d      = (cur_dir_q == LAST_DIR) ? 2'd0 : cur_dir_q + 2'd1;
                        walked_d       = 1'b0;
                        timer_load_val = GREEN_LD;
                    end
                end
                ST_WALK: begin
                    state_d        = ST_ALL_RED;
                    walked_d       = 1'b1;
                    timer_load_val = ALL_RED_LD;
                end
                ST_FLASH: begin
                    if (!flash_mode) begin
                        // Leave so that the next green goes to approach 0.
                        state_d        = ST_ALL_RED;
                        cur_dir_d      = LAST_DIR;
                        timer_load_val = ALL_RED_LD;
                    end else begin
                        toggle_d       = ~toggle_q;
                        timer_load_val = FLASH_LD;
                    end
                end
                default: begin
                    state_d        = ST_ALL_RED;
                    timer_load_val = ALL_RED_LD;
                end
            endcase
        end
    end

    // State and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_ALL_RED;
            cur_dir_q     <= LAST_DIR;
            ped_pending_q <= 1'b0;
            walked_q      <= 1'b0;
            toggle_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_dir_q     <= cur_dir_d;
            ped_pending_q <= ped_pending_d;
            walked_q      <= walked_d;
            toggle_q      <= toggle_d;
        end
    end

    // Per-approach lamp decode from registered state.
    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
        logic [2:0] lamp;

        // Served approach shows green/yellow, others red; flash blinks all.
        always_comb begin
            lamp = LIGHT_RED;
            case (state_q)
                ST_GREEN:  if (cur_dir_q == 2'(gi)) lamp = LIGHT_GREEN;
                ST_YELLOW: if (cur_dir_q == 2'(gi)) lamp = LIGHT_YELLOW;
                ST_FLASH:  lamp = toggle_q ? LIGHT_OFF : LIGHT_YELLOW;
                default:   lamp = LIGHT_RED;
            endcase
        end

        assign lights[3*gi +: 3] = lamp;
    end

    assign ped_walk = (state_q == ST_WALK);
    assign in_flash = (state_q == ST_FLASH);
    assign cur_dir  = cur_dir_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl. Expected lamp sequences are
// queued from the phase schedule and popped one per cycle.
module tb_traffic_light_ctrl;

    localparam int K_RED  = 0;
    localparam int K_GRN  = 1;
    localparam int K_YEL  = 2;
    localparam int K_WALK = 3;
    localparam int K_FON  = 4;
    localparam int K_FOFF = 5;

    typedef struct {
        logic [5:0] lights;
        logic       walk;
        logic       flash;
        logic [1:0] dir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, en, flash_mode, ped_req;
    logic [5:0]  lights;
    logic        ped_walk, in_flash;
    logic [1:0]  cur_dir;

    logic        rst4_n, en4, flash4, ped4;
    logic [11:0] lights4;
    logic        ped_walk4, in_flash4;
    logic [1:0]  cur_dir4;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    traffic_light_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flash_mode (flash_mode),
        .ped_req    (ped_req),
        .lights     (lights),
        .ped_walk   (ped_walk),
        .cur_dir    (cur_dir),
        .in_flash   (in_flash)
    );

    traffic_light_ctrl #(.NUM_DIR(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst4_n),
        .en         (en4),
        .flash_mode (flash4),
        .ped_req    (ped4),
        .lights     (lights4),
        .ped_walk   (ped_walk4),
        .cur_dir    (cur_dir4),
        .in_flash   (in_flash4)
    );

    // Queue n cycles of one expected phase for the two-approach DUT.
    function automatic void push_phase(input int kind, input int dir, input int n);
        exp_t x;
        for (int d = 0; d < 2; d++) begin
            case (kind)
                K_GRN:   x.lights[3*d +: 3] = (d == dir) ? 3'b001 : 3'b100;
                K_YEL:   x.lights[3*d +: 3] = (d == dir) ? 3'b010 : 3'b100;
                K_FON:   x.lights[3*d +: 3] = 3'b010;
                K_FOFF:  x.lights[3*d +: 3] = 3'b000;
                default: x.lights[3*d +: 3] = 3'b100;
            endcase
        end
        x.walk  = (kind == K_WALK);
        x.flash = (kind == K_FON) || (kind == K_FOFF);
        x.dir   = 2'(dir);
        for (int i = 0; i < n; i++) sb.push_back(x);
    endfunction

    // Reset the two-approach DUT; returns at the negedge before cycle 0.
    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; flash_mode = 1'b0; ped_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sb.delete();
        rst_n = 1'b0; en = 1'b1; flash_mode = 1'b1; ped_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (lights !== 6'b100100 || ped_walk !== 1'b0 || in_flash !== 1'b0 || cur_dir !== 2'd1) begin
            errors++;
            $display("FAIL reset_state: got lights=%b walk=%b flash=%b dir=%0d, expected lights=100100 walk=0 flash=0 dir=1",
                     lights, ped_walk, in_flash, cur_dir);
        end
        // Requests seen only under reset must leave no trace.
        flash_mode = 1'b0; ped_req = 1'b0; rst_n = 1'b1;
        push_phase(K_RED, 1, 2); push_phase(K_GRN, 0, 8); push_phase(K_YEL, 0, 3);
        push_phase(K_RED, 0, 2); push_phase(K_GRN, 1, 2);
        for (int c = 0; c < 17; c++) begin
            e = sb.pop_front();
            checks++;
            if (lights !== e.lights || ped_walk !== e.walk || in_flash !== e.flash || cur_dir !== e.dir) begin
                errors++;
                $display("FAIL reset_release cycle %0d: got lights=%b walk=%b flash=%b dir=%0d, expected lights=%b walk=%b flash=%b dir=%0d",
                         c, lights, ped_walk, in_flash, cur_dir, e.lights, e.walk, e.flash, e.dir);
            end
            @(negedge clk);
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_free_run();
        sb.delete();
        do_reset();
        push_phase(K_RED, 1, 2); push_phase(K_GRN, 0, 8); push_phase(K_YEL, 0, 3);
        push_phase(K_RED, 0, 2); push_phase(K_GRN, 1, 8); push_phase(K_YEL, 1, 3);
        push_phase(K_RED, 1, 2); push_phase(K_GRN, 0, 3);
        for (int c = 0; c < 31; c++) begin
            e = sb.pop_front();
            checks++;
            if (lights !== e.lights || ped_walk !== e.walk || in_flash !== e.flash || cur_dir !== e.dir) begin
                errors++;
                $display("FAIL free_run cycle %0d: got lights=%b walk=%b flash=%b dir=%0d, expected lights=%b walk=%b flash=%b dir=%0d",
                         c, lights, ped_walk, in_flash, cur_dir, e.lights, e.walk, e.flash, e.dir);
            end
            @(negedge clk);
        end
        $display("test_free_run done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_ped_walk();
        sb.delete();
        do_reset();
        push_phase(K_RED, 1, 2); push_phase(K_GRN, 0, 8); push_phase(K_YEL, 0, 3);
        push_phase(K_RED, 0, 2); push_phase(K_WALK, 0, 6); push_phase(K_RED, 0, 2);
        push_phase(K_GRN, 1, 8); push_phase(K_YEL, 1, 3); push_phase(K_RED, 1, 2);
        push_phase(K_GRN, 0, 2);
        for (int c = 0; c < 38; c++) begin
            ped_req = (c == 4);
            e = sb.pop_front();
            checks++;
            if (lights !== e.lights || ped_walk !== e.walk || in_flash !== e.flash || cur_dir !== e.dir) begin
                errors++;
                $display("FAIL ped_walk cycle %0d: got lights=%b walk=%b flash=%b dir=%0d, expected lights=%b walk=%b flash=%b dir=%0d",
                         c, lights, ped_walk, in_flash, cur_dir, e.lights, e.walk, e.flash, e.dir);
            end
            @(negedge clk);
        end
        ped_req = 1'b0;
        $display("test_ped_walk done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_flash();
        sb.delete();
        do_reset();
        push_phase(K_RED, 1, 2); push_phase(K_GRN, 0, 8); push_phase(K_YEL, 0, 3);
        push_phase(K_RED, 0, 2); push_phase(K_FON, 0, 4); push_phase(K_FOFF, 0, 4);
        push_phase(K_FON, 0, 4); push_phase(K_RED, 1, 2); push_phase(K_GRN, 0, 8);
        for (int c = 0; c < 37; c++) begin
            flash_mode = (c >= 3) && (c < 24);
            e = sb.pop_front();
            checks++;
            if (lights !== e.lights || ped_walk !== e.walk || in_flash !== e.flash || cur_dir !== e.dir) begin
                errors++;
                $display("FAIL flash cycle %0d: got lights=%b walk=%b flash=%b dir=%0d, expected lights=%b walk=%b flash=%b dir=%0d",
                         c, lights, ped_walk, in_flash, cur_dir, e.lights, e.walk, e.flash, e.dir);
            end
            @(negedge clk);
        end
        flash_mode = 1'b0;
        $display("test_flash done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_mid_reset();
        sb.delete();
        do_reset();
        push_phase(K_RED, 1, 2); push_phase(K_GRN, 0, 5);
        push_phase(K_RED, 1, 2); push_phase(K_GRN, 0, 4);
        for (int c = 0; c < 13; c++) begin
            if (c == 6) rst_n = 1'b0;
            if (c == 7) rst_n = 1'b1;
            e = sb.pop_front();
            checks++;
            if (lights !== e.lights || ped_walk !== e.walk || in_flash !== e.flash || cur_dir !== e.dir) begin
                errors++;
                $display("FAIL mid_reset cycle %0d: got lights=%b walk=%b flash=%b dir=%0d, expected lights=%b walk=%b flash=%b dir=%0d",
                         c, lights, ped_walk, in_flash, cur_dir, e.lights, e.walk, e.flash, e.dir);
            end
            @(negedge clk);
        end
        $display("test_mid_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_en_stretch();
        sb.delete();
        do_reset();
        push_phase(K_RED, 1, 2); push_phase(K_GRN, 0, 8); push_phase(K_YEL, 0, 8);
        push_phase(K_RED, 0, 2); push_phase(K_GRN, 1, 3);
        for (int c = 0; c < 23; c++) begin
            en = !((c >= 11) && (c <= 15));
            e = sb.pop_front();
            checks++;
            if (lights !== e.lights || ped_walk !== e.walk || in_flash !== e.flash || cur_dir !== e.dir) begin
                errors++;
                $display("FAIL en_stretch cycle %0d: got lights=%b walk=%b flash=%b dir=%0d, expected lights=%b walk=%b flash=%b dir=%0d",
                         c, lights, ped_walk, in_flash, cur_dir, e.lights, e.walk, e.flash, e.dir);
            end
            @(negedge clk);
        end
        en = 1'b1;
        $display("test_en_stretch done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_four_dir();
        logic [11:0] prev;
        int          non_red;
        int          greens;
        rst4_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst4_n = 1'b1;
        prev   = 12'b100100100100;
        greens = 0;
        for (int c = 0; c < 200; c++) begin
            non_red = 0;
            for (int d = 0; d < 4; d++) begin
                if (lights4[3*d +: 3] != 3'b100) non_red++;
                if (lights4[3*d +: 3] == 3'b001 && prev[3*d +: 3] != 3'b001) begin
                    checks++;
                    if (d != (greens % 4)) begin
                        errors++;
                        $display("FAIL four_dir_order cycle %0d: got green on approach %0d, expected approach %0d",
                                 c, d, greens % 4);
                    end
                    greens++;
                end
            end
            checks++;
            if (non_red > 1) begin
                errors++;
                $display("FAIL four_dir_exclusive cycle %0d: got %0d non-red approaches (lights=%b), expected at most 1",
                         c, non_red, lights4);
            end
            prev = lights4;
            @(negedge clk);
        end
        checks++;
        if (greens != 16) begin
            errors++;
            $display("FAIL four_dir_count: got %0d greens in 200 cycles, expected 16", greens);
        end
        $display("test_four_dir done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; flash_mode = 1'b0; ped_req = 1'b0;
        rst4_n = 1'b0; en4 = 1'b1; flash4 = 1'b0; ped4 = 1'b0;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_ped_walk();
        test_flash();
        test_mid_reset();
        test_en_stretch();
        test_four_dir();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised intersection controller, successor to the two-direction `traffic_light` block. It sequences green/yellow/all-red phases across `NUM_DIR` approaches using an internal phase timer; no external `timer_done` strobe is needed. It also adds a latched pedestrian walk phase, a flashing-yellow maintenance mode and a global freeze enable. It sits directly behind the lamp drivers; all outputs are Moore (decoded from registered state only).

## Interface
- `NUM_DIR`, 2: number of approaches, legal 2..4; served in order 0,1,…,NUM_DIR-1, then wraps.
- `GREEN_CYCLES`, 8: green duration per approach, ≥1.
- `YELLOW_CYCLES`, 3: yellow duration, ≥1.
- `ALL_RED_CYCLES`, 2: clearance interval, ≥1.
- `WALK_CYCLES`, 6: pedestrian walk duration, ≥1.
- `FLASH_CYCLES`, 4: half-period of flash toggle, ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  1 = run; 0 = freeze timer, state and toggle (outputs hold).
- `flash_mode`  in  1  level request for flashing-yellow mode.
- `ped_req`  in  1  pedestrian request; single-cycle pulse is sufficient.
- `lights`  out  3*NUM_DIR  per-approach lamp, approach d at bits [3d+2:3d]; one-hot {red,yellow,green}: 100 red, 010 yellow, 001 green, 000 dark.
- `ped_walk`  out  1  walk indication.
- `cur_dir`  out  2  approach index currently or most recently served.
- `in_flash`  out  1  high while in FLASH.

## Operation
- States: ALL_RED, GREEN, YELLOW, WALK, FLASH.
- Timer: down-counter loaded with (duration−1) on state entry; state exits on the cycle the counter is 0 and `en`=1. Each state therefore lasts exactly its duration in enabled cycles.
- GREEN → YELLOW → ALL_RED, all on the same `cur_dir`.
- ALL_RED exit, in priority order:
  - `flash_mode`=1 → FLASH.
  - else `ped_pending`=1 and `walked`=0 → WALK.
  - else GREEN with `cur_dir` ← (cur_dir+1) mod NUM_DIR.
- WALK → ALL_RED with `walked`=1. `walked` clears on GREEN entry.
- `ped_pending` is set by `ped_req` in any state except WALK and cleared on WALK entry. A `ped_req` on the WALK-entry cycle is absorbed by that walk.
- FLASH: all approaches toggle 010/000 every FLASH_CYCLES, starting at 010. When `flash_mode`=0 is sampled at a half-period boundary, go to ALL_RED with `cur_dir`=NUM_DIR-1, so the next green is approach 0.
- `flash_mode` is only honoured at the ALL_RED exit. A green is never cut short and yellow is never skipped.
- Lamp decode:
  - GREEN/YELLOW: 001/010 on `cur_dir`, 100 on every other approach.
  - ALL_RED and WALK: 100 on all approaches.
  - `ped_walk`=1 only in WALK.

## Timing
- Reset values (rst_n sampled low at a rising edge): state ALL_RED, timer ALL_RED_CYCLES-1, `cur_dir`=NUM_DIR-1, `ped_pending`=0, `walked`=0, toggle=0. Outputs: all lights 100, `ped_walk`=0, `in_flash`=0.
- Reset dominates every other input. Mid-phase reset returns to all-red on the next edge, with no yellow.
- With defaults, cycle 0 is the first edge with `rst_n`=1:
  - cycles 0–1: ALL_RED
  - cycles 2–9: GREEN dir0
  - cycles 10–12: YELLOW dir0
  - cycles 13–14: ALL_RED
  - cycle 15 onward: GREEN dir1
- Input to output latency: 1 cycle (registered state). No combinational path from any input to any output.
- `en`=0 on a terminal cycle: the transition waits until `en` returns to 1.

## Structure
- Package `traffic_pkg`: state enum `tl_state_t`, lamp constants `LIGHT_RED`/`LIGHT_YELLOW`/`LIGHT_GREEN`/`LIGHT_OFF`.
- Timer width is a localparam: `$clog2` of the largest duration, +1.
- Sub-module `phase_timer`: loadable down-counter with `load`, `load_val`, `en` and a `done` output (count==0). Instantiated once.
- Top contains the FSM, `ped_pending`/`walked` flags, flash toggle and lamp decode.
- Elaboration-time `$error` for NUM_DIR outside 2..4 or any duration <1.

## Test plan
- Reset then free-run, defaults, NUM_DIR=2 → lights/timing exactly as in the Timing section; dir1 green at cycles 15–22; dir0 green again at cycle 28.
- `ped_req` pulse at cycle 4 → ALL_RED 13–14, WALK 15–20 (`ped_walk`=1, all red), ALL_RED 21–22, GREEN dir1 from 23.
- `flash_mode`=1 at cycle 3 → no effect until cycle 15; then lights toggle 010/000 every 4 cycles, `in_flash`=1. Drop the request → ALL_RED, then GREEN dir0.
- NUM_DIR=4 → green order 0,1,2,3,0; exactly one non-red approach at any time; checked by assertion over 200 cycles.
- Reset asserted at cycle 6 (mid-green) → all lights 100 next cycle. Hold `en`=0 for 5 cycles during yellow → yellow stretched by exactly 5 cycles.
